// File: rtl/shared_ram_arb_if.sv
// Read/write client bundle for shared_ram_arb: one read port plus NUM_WR packed write ports.
// Optional SHARED_RAM_ARB_WMASK_EN adds a per-nibble write mask per port.
interface shared_ram_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14,
    parameter int NUM_WR = 2
);
    logic                       rden;
    logic [ADDR_W-1:0]          raddr;
    logic [DATA_W-1:0]          rdata;
    logic                       rvalid;
    logic [NUM_WR-1:0]          wren;
    logic [NUM_WR*ADDR_W-1:0]   waddr;
    logic [NUM_WR*DATA_W-1:0]   wdata;
    logic [NUM_WR-1:0]          wrack;
`ifdef SHARED_RAM_ARB_WMASK_EN
    logic [NUM_WR*(DATA_W/4)-1:0] wmask;

    modport master (output rden, raddr, wren, waddr, wdata, wmask, input rdata, rvalid, wrack);
    modport slave  (input rden, raddr, wren, waddr, wdata, wmask, output rdata, rvalid, wrack);
`else
    modport master (output rden, raddr, wren, waddr, wdata, input rdata, rvalid, wrack);
    modport slave  (input rden, raddr, wren, waddr, wdata, output rdata, rvalid, wrack);
`endif
endinterface

// File: rtl/shared_ram_arb.sv
// Single-port RAM shared by one reader and NUM_WR round-robin writers; reads win unless
// the starvation counter forces a write. Read latency 1; writes acked one cycle after the
// write edge. Optional nibble write mask via SHARED_RAM_ARB_WMASK_EN.
module shared_ram_arb #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 14,
    parameter int NUM_WR     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           resetn,
    shared_ram_arb_if.slave bus
);
    localparam int         DEPTH = 2 ** ADDR_W;
    localparam int         PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam logic [7:0] SMAX  = 8'(STARVE_MAX);
`ifdef SHARED_RAM_ARB_WMASK_EN
    localparam int         NIB   = DATA_W / 4;
`endif

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;
    logic [NUM_WR-1:0] wrack_q;
    logic [7:0]        starve_cnt;
    logic [PTR_W-1:0]  rr_ptr;

    logic [NUM_WR-1:0] elig;
    logic              any_elig;
    logic              force_wr;
    logic              rd_acc;
    logic              wr_do;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  idx_hi;
    logic [PTR_W-1:0]  idx_lo;
    logic              found_hi;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef SHARED_RAM_ARB_WMASK_EN
    logic [NIB-1:0]    wr_mask;
`endif

    // A port whose ack is showing was just served and must re-request before it competes again.
    assign elig = bus.wren & ~wrack_q;

    // Round robin: lowest eligible port at or above rr_ptr, else lowest eligible overall.
    always_comb begin
        idx_hi   = '0;
        idx_lo   = '0;
        found_hi = 1'b0;
        any_elig = 1'b0;
        for (int i = NUM_WR - 1; i >= 0; i--) begin
            if (elig[i]) begin
                idx_lo   = PTR_W'(i);
                any_elig = 1'b1;
                if (i >= int'(rr_ptr)) begin
                    idx_hi   = PTR_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win_idx = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
`ifdef SHARED_RAM_ARB_WMASK_EN
        wr_mask = '0;
`endif
        for (int i = 0; i < NUM_WR; i++) begin
            if (PTR_W'(i) == win_idx) begin
                wr_addr = bus.waddr[i*ADDR_W +: ADDR_W];
                wr_data = bus.wdata[i*DATA_W +: DATA_W];
`ifdef SHARED_RAM_ARB_WMASK_EN
                wr_mask = bus.wmask[i*NIB +: NIB];
`endif
            end
        end
    end

    assign force_wr = any_elig && (starve_cnt == SMAX);
    assign rd_acc   = bus.rden && !force_wr;
    assign wr_do    = !rd_acc && any_elig;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            wrack_q    <= '0;
            starve_cnt <= '0;
            rr_ptr     <= '0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc)
                rdata_q <= mem[bus.raddr];
            wrack_q <= '0;
            if (wr_do) begin
                wrack_q[win_idx] <= 1'b1;
                rr_ptr           <= (win_idx == PTR_W'(NUM_WR - 1)) ? '0 : win_idx + 1'b1;
                starve_cnt       <= '0;
            end else if (rd_acc && any_elig && starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // Array has no reset; resetn only gates writes while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && wr_do) begin
`ifdef SHARED_RAM_ARB_WMASK_EN
            for (int n = 0; n < NIB; n++) begin
                if (wr_mask[n])
                    mem[wr_addr][n*4 +: 4] <= wr_data[n*4 +: 4];
            end
`else
            mem[wr_addr] <= wr_data;
`endif
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wrack  = wrack_q;
endmodule

// File: tb/tb_shared_ram_arb.sv
// Directed bench for shared_ram_arb (NUM_WR=2, STARVE_MAX=4); mask scenario built only
// when SHARED_RAM_ARB_WMASK_EN is defined.
module tb_shared_ram_arb;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 14;
    localparam int NUM_WR     = 2;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    shared_ram_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR)) bus ();

    shared_ram_arb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.waddr[p*ADDR_W +: ADDR_W] = a;
        bus.wdata[p*DATA_W +: DATA_W] = d;
`ifdef SHARED_RAM_ARB_WMASK_EN
        bus.wmask[p*(DATA_W/4) +: (DATA_W/4)] = '1;
`endif
    endtask

    // Single write with the reader idle: request, one edge to write, then release.
    task automatic do_write(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.rden = 1'b0;
        set_port(p, a, d);
        bus.wren = '0;
        bus.wren[p] = 1'b1;
        step();
        bus.wren = '0;
        step();
    endtask

    task automatic test_reset();
        bus.rden  = 1'b0;
        bus.raddr = '0;
        bus.wren  = '0;
        bus.waddr = '0;
        bus.wdata = '0;
`ifdef SHARED_RAM_ARB_WMASK_EN
        bus.wmask = '1;
`endif
        #2 resetn = 1'b0;
        #1;
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected %h", bus.rdata, 16'h0000); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected %b", bus.rvalid, 1'b0); end
        checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL reset_wrack: got %b expected %b", bus.wrack, 2'b00); end
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        step();
    endtask

    task automatic test_two_writes();
        bus.rden = 1'b0;
        set_port(0, 14'd5, 16'h1111);
        set_port(1, 14'd6, 16'h2222);
        bus.wren = 2'b11;
        step();
        checks++; if (bus.wrack !== 2'b01) begin errors++; $display("FAIL rr_first_ack: got %b expected %b", bus.wrack, 2'b01); end
        bus.wren = 2'b10;
        step();
        checks++; if (bus.wrack !== 2'b10) begin errors++; $display("FAIL rr_second_ack: got %b expected %b", bus.wrack, 2'b10); end
        bus.wren = 2'b00;
        step();
        checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL rr_ack_clear: got %b expected %b", bus.wrack, 2'b00); end
        bus.rden  = 1'b1;
        bus.raddr = 14'd5;
        step();
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h1111) begin errors++; $display("FAIL rd_addr5: got v=%b d=%h expected v=1 d=%h", bus.rvalid, bus.rdata, 16'h1111); end
        bus.raddr = 14'd6;
        step();
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h2222) begin errors++; $display("FAIL rd_addr6: got v=%b d=%h expected v=1 d=%h", bus.rvalid, bus.rdata, 16'h2222); end
        bus.rden = 1'b0;
        step();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop: got %b expected %b", bus.rvalid, 1'b0); end
        checks++; if (bus.rdata !== 16'h2222) begin errors++; $display("FAIL rdata_hold: got %h expected %h", bus.rdata, 16'h2222); end
    endtask

    task automatic test_read_stream();
        logic [DATA_W-1:0] exp_d [3];
        exp_d[0] = 16'hA000;
        exp_d[1] = 16'h0B01;
        exp_d[2] = 16'h00C2;
        for (int i = 0; i < 3; i++) do_write(i % NUM_WR, ADDR_W'(i), exp_d[i]);
        bus.rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.raddr = ADDR_W'(i);
            step();
            checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== exp_d[i]) begin errors++; $display("FAIL stream_%0d: got v=%b d=%h expected v=1 d=%h", i, bus.rvalid, bus.rdata, exp_d[i]); end
        end
        bus.rden = 1'b0;
        step();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b expected %b", bus.rvalid, 1'b0); end
    endtask

    task automatic test_starvation();
        bus.rden  = 1'b1;
        bus.raddr = 14'd0;
        set_port(0, 14'd7, 16'h7777);
        bus.wren = 2'b01;
        for (int i = 0; i < STARVE_MAX; i++) begin
            step();
            checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL starve_rd_%0d: got rvalid=%b expected 1", i, bus.rvalid); end
            checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL starve_noack_%0d: got %b expected %b", i, bus.wrack, 2'b00); end
        end
        step();
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL starve_forced_rvalid: got %b expected %b", bus.rvalid, 1'b0); end
        checks++; if (bus.wrack !== 2'b01) begin errors++; $display("FAIL starve_forced_ack: got %b expected %b", bus.wrack, 2'b01); end
        checks++; if (bus.rdata !== 16'hA000) begin errors++; $display("FAIL starve_rdata_hold: got %h expected %h", bus.rdata, 16'hA000); end
        bus.wren = 2'b00;
        step();
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'hA000) begin errors++; $display("FAIL starve_resume: got v=%b d=%h expected v=1 d=%h", bus.rvalid, bus.rdata, 16'hA000); end
        checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL starve_ack_clear: got %b expected %b", bus.wrack, 2'b00); end
        bus.raddr = 14'd7;
        step();
        checks++; if (bus.rdata !== 16'h7777) begin errors++; $display("FAIL starve_written: got %h expected %h", bus.rdata, 16'h7777); end
        bus.rden = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        do_write(1, 14'd3, 16'hABCD);
        bus.rden  = 1'b1;
        bus.raddr = 14'd3;
        step();
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'hABCD) begin errors++; $display("FAIL wr_rd_abcd: got v=%b d=%h expected v=1 d=%h", bus.rvalid, bus.rdata, 16'hABCD); end
        do_write(0, 14'h3FFF, 16'hBEEF);
        do_write(1, 14'h0000, 16'h0F0F);
        bus.rden  = 1'b1;
        bus.raddr = 14'h3FFF;
        step();
        checks++; if (bus.rdata !== 16'hBEEF) begin errors++; $display("FAIL top_addr: got %h expected %h", bus.rdata, 16'hBEEF); end
        bus.raddr = 14'h0000;
        step();
        checks++; if (bus.rdata !== 16'h0F0F) begin errors++; $display("FAIL bottom_addr: got %h expected %h", bus.rdata, 16'h0F0F); end
        bus.rden = 1'b0;
        step();
    endtask

    task automatic test_withdraw();
        bus.rden  = 1'b1;
        bus.raddr = 14'd3;
        set_port(0, 14'd3, 16'h5555);
        bus.wren = 2'b01;
        step();
        checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL withdraw_ack1: got %b expected %b", bus.wrack, 2'b00); end
        checks++; if (bus.rdata !== 16'hABCD) begin errors++; $display("FAIL withdraw_rd1: got %h expected %h", bus.rdata, 16'hABCD); end
        bus.wren = 2'b00;
        step();
        checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL withdraw_ack2: got %b expected %b", bus.wrack, 2'b00); end
        checks++; if (bus.rdata !== 16'hABCD) begin errors++; $display("FAIL withdraw_rd2: got %h expected %h", bus.rdata, 16'hABCD); end
        bus.rden = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.rden = 1'b0;
        set_port(1, 14'd9, 16'h9999);
        bus.wren = 2'b10;
        step();
        checks++; if (bus.wrack !== 2'b10) begin errors++; $display("FAIL mid_ack_before: got %b expected %b", bus.wrack, 2'b10); end
        bus.wren = 2'b00;
        #3 resetn = 1'b0;
        #1;
        checks++; if (bus.wrack !== 2'b00) begin errors++; $display("FAIL mid_ack_async: got %b expected %b", bus.wrack, 2'b00); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL mid_rdata_async: got %h expected %h", bus.rdata, 16'h0000); end
        #2 resetn = 1'b1;
        step();
        do_write(0, 14'd10, 16'hAAAA);
        bus.rden  = 1'b1;
        bus.raddr = 14'd10;
        step();
        checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'hAAAA) begin errors++; $display("FAIL mid_rd_before: got v=%b d=%h expected v=1 d=%h", bus.rvalid, bus.rdata, 16'hAAAA); end
        bus.rden = 1'b0;
        #3 resetn = 1'b0;
        #1;
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL mid_rvalid_async: got %b expected %b", bus.rvalid, 1'b0); end
        checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL mid_rdata2_async: got %h expected %h", bus.rdata, 16'h0000); end
        #2 resetn = 1'b1;
        set_port(0, 14'd11, 16'h0011);
        set_port(1, 14'd12, 16'h0012);
        bus.wren = 2'b11;
        step();
        checks++; if (bus.wrack !== 2'b01) begin errors++; $display("FAIL mid_first_grant: got %b expected %b", bus.wrack, 2'b01); end
        bus.wren = 2'b00;
        step();
    endtask

`ifdef SHARED_RAM_ARB_WMASK_EN
    task automatic test_wmask();
        do_write(0, 14'd20, 16'h1234);
        bus.rden = 1'b0;
        set_port(1, 14'd20, 16'hFFFF);
        bus.wmask[1*(DATA_W/4) +: (DATA_W/4)] = 4'b0101;
        bus.wren = 2'b10;
        step();
        bus.wren = 2'b00;
        step();
        set_port(0, 14'd20, 16'h0000);
        bus.wmask[0 +: (DATA_W/4)] = 4'b0000;
        bus.wren = 2'b01;
        step();
        checks++; if (bus.wrack !== 2'b01) begin errors++; $display("FAIL mask_zero_ack: got %b expected %b", bus.wrack, 2'b01); end
        bus.wren  = 2'b00;
        bus.wmask = '1;
        bus.rden  = 1'b1;
        bus.raddr = 14'd20;
        step();
        checks++; if (bus.rdata !== 16'h1F3F) begin errors++; $display("FAIL mask_merge: got %h expected %h", bus.rdata, 16'h1F3F); end
        bus.rden = 1'b0;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_two_writes();
        test_read_stream();
        test_starvation();
        test_write_read();
        test_withdraw();
        test_reset_mid();
`ifdef SHARED_RAM_ARB_WMASK_EN
        test_wmask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
